// File: rtl/pa_fdsu_wb_buf.sv
// Two-entry writeback FIFO between the FDSU pack stage and the FP register-file
// write port; also keeps sticky fflags and flags pending-destination hazards.
module pa_fdsu_wb_buf (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        fdsu_ex4_wb_vld,
  input  logic [31:0] fdsu_frbus_data,
  input  logic [4:0]  fdsu_frbus_fflags,
  input  logic [4:0]  fdsu_frbus_freg,
  input  logic        ctrl_fdsu_flush,
  input  logic        rf_fdsu_wb_grant,
  input  logic        cp0_fdsu_fflags_clr,
  input  logic [4:0]  idu_fdsu_src_freg,
  output logic        fdsu_wb_buf_full,
  output logic        fdsu_rf_wb_vld,
  output logic [31:0] fdsu_rf_wb_data,
  output logic [4:0]  fdsu_rf_wb_freg,
  output logic [4:0]  fdsu_rf_wb_fflags,
  output logic [4:0]  fdsu_sticky_fflags,
  output logic        fdsu_wb_buf_freg_hit
);

  logic [31:0] data_q   [2];
  logic [31:0] data_d   [2];
  logic [4:0]  fflags_q [2];
  logic [4:0]  fflags_d [2];
  logic [4:0]  freg_q   [2];
  logic [4:0]  freg_d   [2];
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  sticky_q, sticky_d;

  logic        push;
  logic        pop;
  logic [1:0]  ent_vld;
  logic        hit;

  assign fdsu_wb_buf_full   = (cnt_q == 2'd2);
  assign fdsu_rf_wb_vld     = (cnt_q != 2'd0);
  assign fdsu_rf_wb_data    = data_q[rptr_q];
  assign fdsu_rf_wb_freg    = freg_q[rptr_q];
  assign fdsu_rf_wb_fflags  = fflags_q[rptr_q];
  assign fdsu_sticky_fflags = sticky_q;
  assign fdsu_wb_buf_freg_hit = hit;

  // Full is taken from registered count only, so a same-cycle pop never frees a slot for push.
  assign push = fdsu_ex4_wb_vld && !fdsu_wb_buf_full && !ctrl_fdsu_flush;
  assign pop  = fdsu_rf_wb_vld && rf_fdsu_wb_grant && !ctrl_fdsu_flush;

  // Next-state for payload, pointers, count and sticky flags.
  always_comb begin
    data_d   = data_q;
    fflags_d = fflags_q;
    freg_d   = freg_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;

    if (push) begin
      data_d[wptr_q]   = fdsu_frbus_data;
      fflags_d[wptr_q] = fdsu_frbus_fflags;
      freg_d[wptr_q]   = fdsu_frbus_freg;
      wptr_d           = ~wptr_q;
    end else begin
      wptr_d = wptr_q;
    end

    if (pop) begin
      rptr_d = ~rptr_q;
    end else begin
      rptr_d = rptr_q;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // Payload is left alone on flush; only occupancy and pointers restart.
    if (ctrl_fdsu_flush) begin
      cnt_d  = 2'd0;
      wptr_d = 1'b0;
      rptr_d = 1'b0;
    end else begin
      cnt_d = cnt_d;
    end

    sticky_d = (cp0_fdsu_fflags_clr ? 5'd0 : sticky_q)
             | (pop ? fflags_q[rptr_q] : 5'd0);
  end

  // Pending-destination hazard over currently occupied entries.
  always_comb begin
    ent_vld[0] = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && (rptr_q == 1'b0));
    ent_vld[1] = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && (rptr_q == 1'b1));
    hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ent_vld[i] && (freg_q[i] == idu_fdsu_src_freg)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

  // State registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i]   <= 32'd0;
        fflags_q[i] <= 5'd0;
        freg_q[i]   <= 5'd0;
      end
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
      sticky_q <= 5'd0;
    end else begin
      data_q   <= data_d;
      fflags_q <= fflags_d;
      freg_q   <= freg_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_pa_fdsu_wb_buf.sv
// Directed self-checking bench for pa_fdsu_wb_buf.
module tb_pa_fdsu_wb_buf;

  logic        clk;
  logic        rst_b;
  logic        wb_vld;
  logic [31:0] in_data;
  logic [4:0]  in_fflags;
  logic [4:0]  in_freg;
  logic        flush;
  logic        grant;
  logic        fclr;
  logic [4:0]  src;
  logic        full;
  logic        vld;
  logic [31:0] out_data;
  logic [4:0]  out_freg;
  logic [4:0]  out_fflags;
  logic [4:0]  sticky;
  logic        hit;

  int total = 0;
  int bad   = 0;

  pa_fdsu_wb_buf dut (
    .forever_cpuclk      (clk),
    .cpurst_b            (rst_b),
    .fdsu_ex4_wb_vld     (wb_vld),
    .fdsu_frbus_data     (in_data),
    .fdsu_frbus_fflags   (in_fflags),
    .fdsu_frbus_freg     (in_freg),
    .ctrl_fdsu_flush     (flush),
    .rf_fdsu_wb_grant    (grant),
    .cp0_fdsu_fflags_clr (fclr),
    .idu_fdsu_src_freg   (src),
    .fdsu_wb_buf_full    (full),
    .fdsu_rf_wb_vld      (vld),
    .fdsu_rf_wb_data     (out_data),
    .fdsu_rf_wb_freg     (out_freg),
    .fdsu_rf_wb_fflags   (out_fflags),
    .fdsu_sticky_fflags  (sticky),
    .fdsu_wb_buf_freg_hit(hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [4:0] fr, input logic [4:0] ff, input logic [31:0] d);
    wb_vld = v; in_freg = fr; in_fflags = ff; in_data = d;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; set_push(1'b0, 5'd0, 5'd0, 32'd0);
    flush = 1'b0; grant = 1'b0; fclr = 1'b0; src = 5'd0;
    #2;
    total++; if (vld !== 1'b0)        begin $display("FAIL reset_vld got=%0h exp=0", vld); bad++; end
    total++; if (full !== 1'b0)       begin $display("FAIL reset_full got=%0h exp=0", full); bad++; end
    total++; if (hit !== 1'b0)        begin $display("FAIL reset_hit got=%0h exp=0", hit); bad++; end
    total++; if (out_data !== 32'd0)  begin $display("FAIL reset_data got=%0h exp=0", out_data); bad++; end
    total++; if (sticky !== 5'd0)     begin $display("FAIL reset_sticky got=%0h exp=0", sticky); bad++; end
    @(negedge clk); @(negedge clk);
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_single();
    grant = 1'b1;
    set_push(1'b1, 5'd5, 5'h01, 32'h3F80_0000);
    step();
    set_push(1'b0, 5'd0, 5'd0, 32'd0);
    total++; if (vld !== 1'b1)               begin $display("FAIL single_vld got=%0h exp=1", vld); bad++; end
    total++; if (out_data !== 32'h3F80_0000) begin $display("FAIL single_data got=%0h exp=3f800000", out_data); bad++; end
    total++; if (out_freg !== 5'd5)          begin $display("FAIL single_freg got=%0d exp=5", out_freg); bad++; end
    total++; if (out_fflags !== 5'h01)       begin $display("FAIL single_fflags got=%0h exp=1", out_fflags); bad++; end
    step();
    total++; if (vld !== 1'b0)    begin $display("FAIL single_empty got=%0h exp=0", vld); bad++; end
    total++; if (sticky !== 5'h01) begin $display("FAIL single_sticky got=%0h exp=1", sticky); bad++; end
  endtask

  task automatic test_full();
    grant = 1'b0; fclr = 1'b1;
    step();
    fclr = 1'b0;
    total++; if (sticky !== 5'h00) begin $display("FAIL clr_sticky got=%0h exp=0", sticky); bad++; end
    set_push(1'b1, 5'd1, 5'h04, 32'h0000_0011);
    step();
    set_push(1'b1, 5'd2, 5'h02, 32'h0000_0022);
    step();
    total++; if (full !== 1'b1)     begin $display("FAIL full_after2 got=%0h exp=1", full); bad++; end
    set_push(1'b1, 5'd3, 5'h01, 32'h0000_0033);
    step();
    set_push(1'b0, 5'd0, 5'd0, 32'd0);
    total++; if (full !== 1'b1)     begin $display("FAIL full_hold got=%0h exp=1", full); bad++; end
    total++; if (out_freg !== 5'd1) begin $display("FAIL full_head got=%0d exp=1", out_freg); bad++; end
    grant = 1'b1;
    step();
    total++; if (out_freg !== 5'd2)          begin $display("FAIL drain2_freg got=%0d exp=2", out_freg); bad++; end
    total++; if (out_data !== 32'h0000_0022) begin $display("FAIL drain2_data got=%0h exp=22", out_data); bad++; end
    total++; if (full !== 1'b0)              begin $display("FAIL drain_full got=%0h exp=0", full); bad++; end
    step();
    total++; if (vld !== 1'b0)     begin $display("FAIL drain_empty got=%0h exp=0", vld); bad++; end
    total++; if (sticky !== 5'h06) begin $display("FAIL drain_sticky got=%0h exp=6", sticky); bad++; end
    grant = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_push(1'b1, 5'd10, 5'h00, 32'hAAAA_0000);
    step();
    set_push(1'b1, 5'd11, 5'h00, 32'hBBBB_0000);
    grant = 1'b1;
    step();
    set_push(1'b0, 5'd0, 5'd0, 32'd0);
    grant = 1'b0;
    total++; if (vld !== 1'b1)               begin $display("FAIL b2b_vld got=%0h exp=1", vld); bad++; end
    total++; if (full !== 1'b0)              begin $display("FAIL b2b_full got=%0h exp=0", full); bad++; end
    total++; if (out_freg !== 5'd11)         begin $display("FAIL b2b_head got=%0d exp=11", out_freg); bad++; end
    total++; if (out_data !== 32'hBBBB_0000) begin $display("FAIL b2b_data got=%0h exp=bbbb0000", out_data); bad++; end
    grant = 1'b1;
    step();
    grant = 1'b0;
    total++; if (vld !== 1'b0) begin $display("FAIL b2b_count1 got=%0h exp=0", vld); bad++; end
  endtask

  task automatic test_hazard_flush();
    set_push(1'b1, 5'd7, 5'h08, 32'h0000_0007);
    step();
    set_push(1'b1, 5'd9, 5'h08, 32'h0000_0009);
    step();
    set_push(1'b0, 5'd0, 5'd0, 32'd0);
    src = 5'd9; #1;
    total++; if (hit !== 1'b1) begin $display("FAIL hit9 got=%0h exp=1", hit); bad++; end
    src = 5'd3; #1;
    total++; if (hit !== 1'b0) begin $display("FAIL hit3 got=%0h exp=0", hit); bad++; end
    src = 5'd7; #1;
    total++; if (hit !== 1'b1) begin $display("FAIL hit7 got=%0h exp=1", hit); bad++; end
    flush = 1'b1; grant = 1'b1;
    set_push(1'b1, 5'd13, 5'h10, 32'h0000_000D);
    step();
    flush = 1'b0; grant = 1'b0;
    set_push(1'b0, 5'd0, 5'd0, 32'd0);
    src = 5'd9; #1;
    total++; if (vld !== 1'b0)     begin $display("FAIL flush_vld got=%0h exp=0", vld); bad++; end
    total++; if (hit !== 1'b0)     begin $display("FAIL flush_hit got=%0h exp=0", hit); bad++; end
    total++; if (full !== 1'b0)    begin $display("FAIL flush_full got=%0h exp=0", full); bad++; end
    total++; if (sticky !== 5'h06) begin $display("FAIL flush_sticky got=%0h exp=6", sticky); bad++; end
  endtask

  task automatic test_sticky_clr();
    grant = 1'b1;
    set_push(1'b1, 5'd4, 5'h19, 32'h0000_0004);
    step();
    set_push(1'b0, 5'd0, 5'd0, 32'd0);
    step();
    total++; if (sticky !== 5'h1F) begin $display("FAIL sticky_1f got=%0h exp=1f", sticky); bad++; end
    grant = 1'b0;
    set_push(1'b1, 5'd12, 5'h10, 32'h0000_000C);
    step();
    set_push(1'b0, 5'd0, 5'd0, 32'd0);
    grant = 1'b1; fclr = 1'b1;
    step();
    grant = 1'b0; fclr = 1'b0;
    total++; if (sticky !== 5'h10) begin $display("FAIL clr_pop got=%0h exp=10", sticky); bad++; end
    total++; if (vld !== 1'b0)     begin $display("FAIL clr_pop_vld got=%0h exp=0", vld); bad++; end
  endtask

  task automatic test_async_reset();
    set_push(1'b1, 5'd20, 5'h03, 32'hDEAD_BEEF);
    step();
    set_push(1'b1, 5'd21, 5'h03, 32'hCAFE_F00D);
    step();
    set_push(1'b0, 5'd0, 5'd0, 32'd0);
    src = 5'd20;
    total++; if (full !== 1'b1) begin $display("FAIL pre_rst_full got=%0h exp=1", full); bad++; end
    #2;
    rst_b = 1'b0;
    #1;
    total++; if (full !== 1'b0)       begin $display("FAIL arst_full got=%0h exp=0", full); bad++; end
    total++; if (vld !== 1'b0)        begin $display("FAIL arst_vld got=%0h exp=0", vld); bad++; end
    total++; if (hit !== 1'b0)        begin $display("FAIL arst_hit got=%0h exp=0", hit); bad++; end
    total++; if (out_data !== 32'd0)  begin $display("FAIL arst_data got=%0h exp=0", out_data); bad++; end
    total++; if (out_freg !== 5'd0)   begin $display("FAIL arst_freg got=%0h exp=0", out_freg); bad++; end
    total++; if (out_fflags !== 5'd0) begin $display("FAIL arst_fflags got=%0h exp=0", out_fflags); bad++; end
    total++; if (sticky !== 5'd0)     begin $display("FAIL arst_sticky got=%0h exp=0", sticky); bad++; end
    @(negedge clk);
    rst_b = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_hazard_flush();
    test_sticky_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
